// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the 32-entry integer register file.
//   X0..X30 are real storage; index 31 (XZR) reads as zero and swallows writes.
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 5;

    typedef logic [IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd31;

    // True when the index names the hardwired zero register.
    function automatic logic is_zero_reg(input reg_idx_t idx);
        return idx == ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_reg_en.sv
// ----------------------------------------------------------------------------
// reg_en
//   WIDTH-bit storage register with write enable and asynchronous
//   active-low clear. One instance per architectural register.
//
// Ports
//   clk    in   capture clock (rising edge)
//   reset  in   asynchronous active-low clear
//   en     in   load enable
//   d      in   WIDTH  next value
//   q      out  WIDTH  stored value
// ----------------------------------------------------------------------------
module reg_en #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile
//   Two-read, one-write register file: 31 writable registers X0..X30 plus
//   the hardwired zero register XZR at index 31. Reads are combinational.
//
// Ports
//   clk            in   write clock (rising edge)
//   reset          in   asynchronous active-low clear of all storage
//   RegWrite       in   write enable
//   WriteRegister  in   5      destination index
//   WriteData      in   WIDTH  write data
//   ReadRegister1  in   5      read port 1 index
//   ReadRegister2  in   5      read port 2 index
//   ReadData1      out  WIDTH  read port 1 data
//   ReadData2      out  WIDTH  read port 2 data
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a write in progress is forwarded to a
//                      read port selecting the same (non-zero) register in
//                      the same cycle. Default build returns the stored value.
// ----------------------------------------------------------------------------
module regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    localparam int NUM_RD = 2;

    // Entry 31 is a constant zero so the read mux needs no special case.
    logic [WIDTH-1:0]      regs [NUM_REGS];
    logic [NUM_REGS-2:0]   wen;
    reg_idx_t              ra       [NUM_RD];
    logic [WIDTH-1:0]      rd_mux   [NUM_RD];
    logic [WIDTH-1:0]      rd_out   [NUM_RD];

    // ------------------------------------------------------------------
    // Write-enable decode: 5-to-32 one-hot gated by RegWrite. The XZR
    // output has no register behind it, so only 31 enables are kept.
    // Reset needs no gating here: reg_en's async clear dominates.
    // ------------------------------------------------------------------
    always_comb begin
        wen = '0;
        for (int i = 0; i < NUM_REGS-1; i++)
            wen[i] = RegWrite && (WriteRegister == reg_idx_t'(i));
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REGS-1; i++) begin : g_reg
        reg_en #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (wen[i]),
            .d     (WriteData),
            .q     (regs[i])
        );
    end

    assign regs[NUM_REGS-1] = '0;

    // ------------------------------------------------------------------
    // Read ports: two 16:1 halves selected by idx[3:0], then a 2:1 on
    // idx[4]. Purely combinational.
    // ------------------------------------------------------------------
    assign ra[0] = ReadRegister1;
    assign ra[1] = ReadRegister2;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [WIDTH-1:0] rd_lo;
        logic [WIDTH-1:0] rd_hi;

        always_comb begin
            rd_lo     = regs[{1'b0, ra[p][3:0]}];
            rd_hi     = regs[{1'b1, ra[p][3:0]}];
            rd_mux[p] = ra[p][4] ? rd_hi : rd_lo;
        end

`ifdef REGFILE_BYPASS_EN
        // Forward a same-cycle write so a write-back result reaches decode
        // without waiting for the edge. XZR is never forwarded.
        logic byp;
        assign byp       = RegWrite && reset && !is_zero_reg(WriteRegister)
                           && (WriteRegister == ra[p]);
        assign rd_out[p] = byp ? WriteData : rd_mux[p];
`else
        assign rd_out[p] = rd_mux[p];
`endif
    end

    assign ReadData1 = rd_out[0];
    assign ReadData2 = rd_out[1];

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;
    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         RegWrite;
    logic [4:0]   WriteRegister;
    logic [W-1:0] WriteData;
    logic [4:0]   ReadRegister1;
    logic [4:0]   ReadRegister2;
    logic [W-1:0] ReadData1;
    logic [W-1:0] ReadData2;

    regfile #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic         port;
        logic [W-1:0] exp;
    } exp_t;

    exp_t         sb [$];
    logic [W-1:0] model [31];
    int           ntests = 0;
    int           nfail  = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mexp(input int r);
        return (r == 31) ? '0 : model[r];
    endfunction

    // Drive both read indices, queue the expected values, then let the
    // combinational path settle and drain the queue against the outputs.
    task automatic rd(input string tag, input int r1, input int r2,
                      input logic [W-1:0] e1, input logic [W-1:0] e2);
        ReadRegister1 = 5'(r1);
        ReadRegister2 = 5'(r2);
        sb.push_back('{tag: $sformatf("%s.p1[%0d]", tag, r1), port: 1'b0, exp: e1});
        sb.push_back('{tag: $sformatf("%s.p2[%0d]", tag, r2), port: 1'b1, exp: e2});
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, e.port ? ReadData2 : ReadData1, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [W-1:0] data);
        RegWrite      = 1'b1;
        WriteRegister = 5'(idx);
        WriteData     = data;
        tick();
        RegWrite      = 1'b0;
        if (idx != 31 && reset) model[idx] = data;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 31; i++) model[i] = '0;
    endtask

    initial begin
        reset         = 1'b0;
        RegWrite      = 1'b1;
        WriteRegister = 5'd2;
        WriteData     = 64'hFFFF;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        clear_model();

        // Reset: everything reads 0, and a write attempted in reset is lost
        for (int i = 0; i < 32; i++) rd("rst_sweep", i, 31 - i, '0, '0);
        tick();
        RegWrite = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rd("rst_wr_lost", 2, 2, '0, '0);

        // Basic write/read
        wr(5, 64'hDEADBEEF_01234567);
        rd("x5", 5, 5, model[5], model[5]);
        for (int i = 0; i < 32; i++) rd("after_x5", i, 31 - i, mexp(i), mexp(31 - i));

        // XZR swallows writes and always reads 0, including mid-write
        RegWrite      = 1'b1;
        WriteRegister = 5'd31;
        WriteData     = '1;
        rd("xzr_pre", 31, 31, '0, '0);
        tick();
        RegWrite = 1'b0;
        rd("xzr_post", 31, 31, '0, '0);

        // Write enable low keeps the old value
        wr(7, 64'hAA);
        RegWrite      = 1'b0;
        WriteRegister = 5'd7;
        WriteData     = 64'h55;
        tick();
        rd("en_low", 7, 5, 64'hAA, model[5]);

        // Same-cycle read of a register being written
        wr(3, 64'h1);
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 64'h2;
`ifdef REGFILE_BYPASS_EN
        rd("same_cyc", 5, 3, model[5], 64'h2);
`else
        rd("same_cyc", 5, 3, model[5], 64'h1);
`endif
        tick();
        RegWrite = 1'b0;
        model[3] = 64'h2;
        rd("same_cyc_post", 3, 3, 64'h2, 64'h2);

        // Full sweep, then async reset part-way through the read-back
        for (int i = 0; i < 31; i++) wr(i, W'(i) * 64'h0101);
        for (int i = 0; i < 31; i++) begin
            if (i == 16) begin
                reset = 1'b0;
                clear_model();
            end
            rd("sweep", i, 30 - i, mexp(i), mexp(30 - i));
        end
        rd("rst_mid", 30, 0, '0, '0);

        // First edge after release accepts the write
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd9;
        WriteData     = 64'h1234_5678_9ABC_DEF0;
        reset         = 1'b1;
        tick();
        RegWrite = 1'b0;
        model[9] = 64'h1234_5678_9ABC_DEF0;
        rd("first_edge", 9, 10, model[9], '0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 64, data width of each register and of every data port.
REQ-002 Port: clk  input  1  single clock; all register writes occur on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; low clears all storage immediately, independent of clk.
REQ-004 Port: RegWrite  input  1  write enable for the write port.
REQ-005 Port: WriteRegister  input  5  destination register index.
REQ-006 Port: WriteData  input  WIDTH  data to be written.
REQ-007 Port: ReadRegister1  input  5  read port 1 index.
REQ-008 Port: ReadRegister2  input  5  read port 2 index.
REQ-009 Port: ReadData1  output  WIDTH  contents selected by ReadRegister1.
REQ-010 Port: ReadData2  output  WIDTH  contents selected by ReadRegister2.

Function
REQ-011 The block SHALL hold 31 writable registers, X0..X30; index 31 (XZR) SHALL hold no storage.
REQ-012 The block SHALL write WriteData into register WriteRegister on a rising clk edge when RegWrite=1, reset=1 and WriteRegister!=31.
REQ-013 The block SHALL leave every register unchanged when RegWrite=0, when WriteRegister=31, or for all registers other than the addressed one.
REQ-014 The block SHALL drive both reads combinationally: ReadDataN SHALL equal the current contents of ReadRegisterN with zero-cycle latency.
REQ-015 The block SHALL drive ReadDataN to 0 whenever ReadRegisterN=31, under all conditions, including when a write to 31 is attempted.
REQ-016 When both read ports select the same index, the block SHALL return identical values on both ports.
REQ-017 A write SHALL become visible on the reads immediately after the capturing clk edge, apart from the bypass in REQ-022.
REQ-018 Each read path SHALL be one 32:1 selection per bit, with no added pipeline register.

Reset
REQ-019 While reset=0, the block SHALL force X0..X30 to 0 asynchronously and SHALL drive ReadData1 and ReadData2 to 0.
REQ-020 While reset=0, the block SHALL ignore writes; an edge coinciding with reset low SHALL store nothing.
REQ-021 The block SHALL accept the first write on the first rising clk edge at which reset=1; reset asserted mid-sequence SHALL discard all prior contents.

Configuration
REQ-022 With REGFILE_BYPASS_EN defined, the block SHALL forward data: when RegWrite=1, reset=1, WriteRegister!=31 and WriteRegister==ReadRegisterN, ReadDataN SHALL equal WriteData in the same cycle, before the edge. This lets a write-back-stage write reach a decode-stage read.
REQ-023 Without REGFILE_BYPASS_EN, the block SHALL return the stored pre-edge value in that case, and the pipeline SHALL cover the hazard by forwarding or stall.

Structure
REQ-024 A shared package regfile_pkg SHALL hold NUM_REGS=32, ZERO_REG=5'd31, IDX_W=5 and a typedef for the register index.
REQ-025 The block SHALL use one sub-module, reg_en: a WIDTH-bit register with write enable and asynchronous active-low clear, instantiated 31 times.
REQ-026 The block SHALL build the write enables with a 5-to-32 one-hot decoder gated by RegWrite. It SHALL build the read selection from the team's existing bit-level mux blocks, as two 16:1 halves plus a 2:1 per bit.

Verification
REQ-027 Bench case (reset): hold reset=0, sweep ReadRegister1/2 over 0..31 -> both reads return 0; a write of 64'hFFFF attempted during reset -> still 0 after release.
REQ-028 Bench case (write/read): write X5=64'hDEADBEEF_01234567 -> reading X5 on either port after the edge returns that value; all other registers still read 0.
REQ-029 Bench case (zero register): RegWrite=1, WriteRegister=31, WriteData=all-ones -> ReadRegister1=31 returns 0 before and after the edge.
REQ-030 Bench case (enable): RegWrite=0, WriteRegister=7, WriteData=64'h55 -> X7 keeps its prior value 64'hAA.
REQ-031 Bench case (same-cycle read): X3=64'h1, then write X3=64'h2 with ReadRegister2=3, sampled before the edge -> 64'h2 with REGFILE_BYPASS_EN defined, 64'h1 without.
REQ-032 Bench case (full sweep): write Xi=i*64'h0101 for i=0..30, then read all pairs (i, 30-i) -> every value correct; asserting reset mid-sweep -> all reads return 0.
